// File: rtl/sin_cu_pkg.sv
// sin_cu_pkg: shared types and constants for the sine Maclaurin control unit.
package sin_cu_pkg;

  // Terms evaluated including x. The datapath counter is 3 bits wide, so this is fixed at 8.
  localparam int N_TERMS = 8;
  // Loop iterations after the initial x term.
  localparam int N_ITERS = N_TERMS - 1;
  // Value of cnt8 in ACC that ends the loop (counter has reached N_ITERS).
  localparam logic LAST_ITER = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_INIT = 3'd1,
    S_MULX = 3'd2,
    S_CNT  = 3'd3,
    S_MULC = 3'd4,
    S_ACC  = 3'd5,
    S_DONE = 3'd6
  } state_e;

endpackage

// File: rtl/sin_cu.sv
// sin_cu: control unit sequencing the sinDU datapath through
// x - x^3/3! + ... - x^15/15!. Every iteration is MULX, CNT, MULC, ACC.
// Optional macro SIN_CU_ABORT_EN adds an abort input that returns to IDLE
// from any busy state without a done pulse.
module sin_cu
  import sin_cu_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
`ifdef SIN_CU_ABORT_EN
  input  logic abort,
`endif
  input  logic cnt8,
  output logic ready,
  output logic done,
  output logic cntUp,
  output logic init0,
  output logic ldX,
  output logic ldT,
  output logic initT1,
  output logic ldS,
  output logic initS1,
  output logic selXR
);

  state_e state_q, state_d;
  logic   abort_hit;

`ifdef SIN_CU_ABORT_EN
  // Abort only matters while a sequence is running; IDLE and DONE finish on their own.
  assign abort_hit = abort && (state_q != S_IDLE) && (state_q != S_DONE);
`else
  assign abort_hit = 1'b0;
`endif

  // State register: the only storage in the control unit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; abort takes priority over the cnt8 loop exit.
  always_comb begin
    state_d = state_q;
    if (abort_hit) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start) state_d = S_INIT;
        S_INIT:  state_d = S_MULX;
        S_MULX:  state_d = S_CNT;
        S_CNT:   state_d = S_MULC;
        S_MULC:  state_d = S_ACC;
        S_ACC:   state_d = (cnt8 == LAST_ITER) ? S_DONE : S_MULX;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output decode from state; ldX is the only Mealy output (captures xBus on acceptance).
  always_comb begin
    ready  = 1'b0;
    done   = 1'b0;
    cntUp  = 1'b0;
    init0  = 1'b0;
    ldX    = 1'b0;
    ldT    = 1'b0;
    initT1 = 1'b0;
    ldS    = 1'b0;
    initS1 = 1'b0;
    selXR  = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        // Gated by rst so nothing strobes while reset is held.
        ldX   = start & rst;
      end
      S_INIT: begin
        init0  = 1'b1;
        initT1 = 1'b1;
        initS1 = 1'b1;
      end
      S_MULX: begin
        selXR = 1'b1;
        ldT   = 1'b1;
      end
      S_CNT:   cntUp = 1'b1;
      S_MULC:  ldT   = 1'b1;
      S_ACC:   ldS   = 1'b1;
      S_DONE:  done  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sin_cu.sv
// tb_sin_cu: self-checking bench for sin_cu. A behavioural sinDU model closes
// the loop so strobe sequencing shows up in the final rBus value; expected
// sines are queued on acceptance and popped on done.
module tb_sin_cu;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        cnt8;
  logic        ready, done, cntUp, init0, ldX, ldT, initT1, ldS, initS1, selXR;
`ifdef SIN_CU_ABORT_EN
  logic        abort;
`endif

  sin_cu dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
`ifdef SIN_CU_ABORT_EN
    .abort  (abort),
`endif
    .cnt8   (cnt8),
    .ready  (ready),
    .done   (done),
    .cntUp  (cntUp),
    .init0  (init0),
    .ldX    (ldX),
    .ldT    (ldT),
    .initT1 (initT1),
    .ldS    (ldS),
    .initS1 (initS1),
    .selXR  (selXR)
  );

  always #5 clk = ~clk;

  // ---------------- datapath model (sinDU) ----------------
  logic [15:0] xBus;
  logic [2:0]  cnt;
  logic [15:0] X, T;
  logic [17:0] S;
  logic [31:0] x2, mul;
  logic [15:0] coef, muxo;
  logic [17:0] rBus;

  // LUT[k] = round(2^16 / ((2k)(2k+1)))
  always_comb begin
    coef = 16'd0;
    case (cnt)
      3'd1: coef = 16'd10923;
      3'd2: coef = 16'd3277;
      3'd3: coef = 16'd1560;
      3'd4: coef = 16'd910;
      3'd5: coef = 16'd596;
      3'd6: coef = 16'd420;
      3'd7: coef = 16'd312;
      default: coef = 16'd0;
    endcase
  end

  assign x2   = X * X;
  assign muxo = selXR ? x2[31:16] : coef;
  assign mul  = T * muxo;
  assign cnt8 = (cnt == 3'd7);
  assign rBus = S;

  always_ff @(posedge clk) begin
    if (ldX)    X <= xBus;
    if (init0)  cnt <= 3'd0;
    else if (cntUp) cnt <= cnt + 3'd1;
    if (initT1) T <= X;
    else if (ldT) T <= mul[31:16];
    if (initS1) S <= {2'b00, X};
    else if (ldS) S <= cnt[0] ? (S - {2'b00, T}) : (S + {2'b00, T});
  end

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  int sb[$];

  function automatic int ref_sin(input logic [15:0] x);
    real xr;
    xr = real'(x) / 65536.0;
    return $rtoi($sin(xr) * 65536.0 + 0.5);
  endfunction

  function automatic logic [8:0] strobes();
    return {done, cntUp, init0, ldX, ldT, initT1, ldS, initS1, selXR};
  endfunction

  // Waits for done (no checking); n = cycle index after acceptance, -1 on timeout.
  task automatic wait_done(input bit keep, output int n, output logic [17:0] r);
    n = -1;
    r = '0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (!keep) start = 1'b0;
      #1;
      if (done) begin
        n = i;
        r = rBus;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [8:0] s;
    int         seen;
    #1;
    s = strobes();
    checks++;
    if (ready !== 1'b1 || s !== 9'd0) begin
      errors++;
      $display("FAIL reset_hold: ready=%b strobes=%b, want ready=1 strobes=0", ready, s);
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (ready !== 1'b1 || strobes() !== 9'd0) begin
      errors++;
      $display("FAIL reset_release: ready=%b strobes=%b, want idle", ready, strobes());
    end
    // run into ACC, then reset asynchronously mid-cycle
    @(negedge clk); xBus = 16'h8000; start = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); start = 1'b0; #1;
      if (ldS) begin seen = 1; break; end
    end
    checks++;
    if (seen != 1) begin
      errors++;
      $display("FAIL reset_reach_acc: ACC seen=%0d, want 1", seen);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b1 || strobes() !== 9'd0) begin
      errors++;
      $display("FAIL reset_mid_acc: ready=%b strobes=%b, want ready=1 strobes=0", ready, strobes());
    end
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++;
      if (ready !== 1'b1 || strobes() !== 9'd0) begin
        errors++;
        $display("FAIL reset_stay_idle[%0d]: ready=%b strobes=%b", i, ready, strobes());
      end
    end
  endtask

  task automatic test_handshake();
    int n, e;
    logic [17:0] r;
    @(negedge clk); xBus = 16'h8000; start = 1'b1; #1;
    checks++;
    if (ldX !== 1'b1) begin
      errors++;
      $display("FAIL hs_ldx: ldX=%b, want 1", ldX);
    end
    sb.push_back(ref_sin(16'h8000));
    wait_done(1'b0, n, r);
    checks++;
    if (n != 30) begin
      errors++;
      $display("FAIL hs_latency: done at cycle %0d, want 30", n);
    end
    if (n > 0) begin
      e = (sb.size() > 0) ? sb.pop_front() : -1000;
      checks++;
      if (int'(r) - e > 2 || int'(r) - e < -2) begin
        errors++;
        $display("FAIL hs_result: rBus=%0h, want %0h +/-2", r, e);
      end
    end
    @(negedge clk); #1;
    checks++;
    if (done !== 1'b0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL hs_after_done: done=%b ready=%b, want 0/1", done, ready);
    end
  endtask

  task automatic test_strobe_order();
    logic [8:0] exp_s;
    int e;
    @(negedge clk); xBus = 16'h4000; start = 1'b1;
    sb.push_back(ref_sin(16'h4000));
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk); start = 1'b0; #1;
      // {done,cntUp,init0,ldX,ldT,initT1,ldS,initS1,selXR}
      if (c == 1)       exp_s = 9'b0_0_1_0_0_1_0_1_0;
      else if (c == 30) exp_s = 9'b1_0_0_0_0_0_0_0_0;
      else case ((c - 2) % 4)
        0:       exp_s = 9'b0_0_0_0_1_0_0_0_1;
        1:       exp_s = 9'b0_1_0_0_0_0_0_0_0;
        2:       exp_s = 9'b0_0_0_0_1_0_0_0_0;
        default: exp_s = 9'b0_0_0_0_0_0_1_0_0;
      endcase
      checks++;
      if (strobes() !== exp_s) begin
        errors++;
        $display("FAIL order_c%0d: strobes=%b, want %b", c, strobes(), exp_s);
      end
      if (c == 30 && done) begin
        e = (sb.size() > 0) ? sb.pop_front() : -1000;
        checks++;
        if (int'(rBus) - e > 2 || int'(rBus) - e < -2) begin
          errors++;
          $display("FAIL order_result: rBus=%0h, want %0h +/-2", rBus, e);
        end
      end
    end
  endtask

  task automatic test_ignored_start();
    int dones = 0, donec = -1, e;
    @(negedge clk); xBus = 16'hFFFF; start = 1'b1;
    sb.push_back(ref_sin(16'hFFFF));
    for (int c = 1; c <= 70; c++) begin
      @(negedge clk);
      start = (c == 5 || c == 20);
      xBus  = start ? 16'h1234 : 16'hFFFF;
      #1;
      if (start) begin
        checks++;
        if (ldX !== 1'b0 || ready !== 1'b0) begin
          errors++;
          $display("FAIL ign_busy_c%0d: ldX=%b ready=%b, want 0/0", c, ldX, ready);
        end
      end
      if (done) begin
        dones++;
        donec = c;
        e = (sb.size() > 0) ? sb.pop_front() : -1000;
        checks++;
        if (int'(rBus) - e > 2 || int'(rBus) - e < -2) begin
          errors++;
          $display("FAIL ign_result: rBus=%0h, want %0h +/-2", rBus, e);
        end
      end
    end
    start = 1'b0;
    checks++;
    if (dones != 1 || donec != 30) begin
      errors++;
      $display("FAIL ign_dones: count=%0d at cycle %0d, want 1 at 30", dones, donec);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] xs [3];
    int run_idx = 0, ndone = 0, last = -1, e;
    xs[0] = 16'h0000; xs[1] = 16'h4000; xs[2] = 16'hC000;
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      if (ready && run_idx < 3) begin
        start = 1'b1;
        xBus  = xs[run_idx];
        sb.push_back(ref_sin(xs[run_idx]));
        run_idx++;
      end
      #1;
      if (done) begin
        e = (sb.size() > 0) ? sb.pop_front() : -1000;
        checks++;
        if (int'(rBus) - e > 2 || int'(rBus) - e < -2) begin
          errors++;
          $display("FAIL b2b_result%0d: rBus=%0h, want %0h +/-2", ndone, rBus, e);
        end
        if (last >= 0) begin
          checks++;
          if (c - last != 31) begin
            errors++;
            $display("FAIL b2b_gap%0d: %0d cycles, want 31", ndone, c - last);
          end
        end
        last = c;
        ndone++;
        if (ndone == 3) begin
          start = 1'b0;
          break;
        end
      end
    end
    start = 1'b0;
    checks++;
    if (ndone != 3) begin
      errors++;
      $display("FAIL b2b_count: %0d dones, want 3", ndone);
    end
  endtask

`ifdef SIN_CU_ABORT_EN
  task automatic test_abort();
    int dones = 0, n, e;
    logic [17:0] r;
    @(negedge clk); xBus = 16'h8000; start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk); start = 1'b0;
      if (c == 12) abort = 1'b1;
    end
    @(negedge clk); abort = 1'b0; #1;
    checks++;
    if (ready !== 1'b1 || strobes() !== 9'd0) begin
      errors++;
      $display("FAIL abort_idle: ready=%b strobes=%b, want idle", ready, strobes());
    end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); #1;
      if (done) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL abort_no_done: %0d dones, want 0", dones);
    end
    @(negedge clk); xBus = 16'h8000; start = 1'b1;
    sb.push_back(ref_sin(16'h8000));
    wait_done(1'b0, n, r);
    checks++;
    if (n != 30) begin
      errors++;
      $display("FAIL abort_rerun_latency: cycle %0d, want 30", n);
    end
    if (n > 0) begin
      e = (sb.size() > 0) ? sb.pop_front() : -1000;
      checks++;
      if (int'(r) - e > 2 || int'(r) - e < -2) begin
        errors++;
        $display("FAIL abort_rerun_result: rBus=%0h, want %0h +/-2", r, e);
      end
    end
  endtask
`endif

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    xBus  = 16'h0000;
`ifdef SIN_CU_ABORT_EN
    abort = 1'b0;
`endif
    test_reset();
    test_handshake();
    test_strobe_order();
    test_ignored_start();
    test_back_to_back();
`ifdef SIN_CU_ABORT_EN
    test_abort();
`endif
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d results outstanding, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
